// File: rtl/wb_regbank.sv
// wb_regbank: pipelined Wishbone register bank with fixed-latency, in-order responses.
// Define WB_REGBANK_ERR_EN to answer out-of-range addresses with wb_err instead of aliasing.
module wb_regbank #(
  parameter int AW              = 32,
  parameter int DW              = 64,
  parameter int NREG            = 16,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_adr,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack,
  output logic              wb_err,
  output logic              wb_stall
);
  localparam int OFS = $clog2(DW/8);
  localparam int IW  = $clog2(NREG);
  localparam int NB  = DW/8;

  logic [DW-1:0]      r_mem [NREG];
  logic [DW-1:0]      r_dat [LATENCY];
  logic [LATENCY-1:0] r_vld;
  logic [1:0]         r_cnt;
  logic               r_rdy;
  logic               w_acc;
  logic               w_oor;
  logic               w_last_err;
  logic               w_done;
  logic [IW-1:0]      w_idx;
  logic [DW-1:0]      w_rd;
  logic               w_unused;

  assign w_unused = &{1'b0, wb_adr};
  assign w_idx    = wb_adr[OFS+IW-1:OFS];
  assign wb_stall = wb_cyc & (r_cnt == 2'(MAX_OUTSTANDING));
  // r_rdy blocks the first edge after reset release even if a strobe is already up
  assign w_acc    = wb_cyc & wb_stb & ~wb_stall & r_rdy;
  assign w_rd     = (w_acc & ~wb_we & ~w_oor) ? r_mem[w_idx] : '0;
  assign wb_ack   = wb_cyc & r_vld[LATENCY-1] & ~w_last_err;
  assign wb_dat_o = wb_ack ? r_dat[LATENCY-1] : '0;
  assign w_done   = wb_ack | wb_err;

`ifdef WB_REGBANK_ERR_EN
  logic [LATENCY-1:0] r_err;

  assign w_oor      = |wb_adr[AW-1:OFS+IW];
  assign w_last_err = r_err[LATENCY-1];
  assign wb_err     = wb_cyc & r_vld[LATENCY-1] & r_err[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err[0] <= w_acc & w_oor;
      for (int i = LATENCY-1; i > 0; i--) r_err[i] <= r_err[i-1];
    end
  end
`else
  assign w_oor      = 1'b0;
  assign w_last_err = 1'b0;
  assign wb_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_acc & wb_we & ~w_oor) begin
      for (int b = 0; b < NB; b++)
        if (wb_sel[b]) r_mem[w_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_rdy <= 1'b0;
      for (int i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_rdy    <= 1'b1;
      r_vld[0] <= wb_cyc & w_acc;
      r_dat[0] <= w_rd;
      for (int i = LATENCY-1; i > 0; i--) begin
        r_vld[i] <= wb_cyc & r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= !wb_cyc ? 2'd0 :
                  (w_acc & ~w_done) ? r_cnt + 2'd1 :
                  (~w_acc & w_done) ? r_cnt - 2'd1 : r_cnt;
  end
endmodule

// File: tb/tb_wb_regbank.sv
// tb_wb_regbank: scoreboard bench for wb_regbank at default parameters.
module tb_wb_regbank;
  localparam int LAT = 2;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [63:0] wb_dat_i = '0;
  logic [7:0]  wb_sel = '0;
  logic [63:0] wb_dat_o;
  logic        wb_ack, wb_err, wb_stall;

  wb_regbank dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_sel(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          err;
    logic [63:0] dat;
  } rsp_t;

  rsp_t        q[$];
  logic [63:0] mem [16];
  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  int          cnt = 0;
  bit          rdy = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h exp %h", tag, n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    bit          e_stall, hit, acc, oor;
    logic [63:0] e_dat;
    logic [3:0]  idx;
    rsp_t        r;
    n++;
    if (!rst_n) begin
      q.delete();
      cnt = 0;
      rdy = 0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      chk("rst_ack", 64'(wb_ack), 64'd0);
      chk("rst_err", 64'(wb_err), 64'd0);
      chk("rst_dat", wb_dat_o, 64'd0);
      chk("rst_stall", 64'(wb_stall), 64'd0);
    end else begin
      e_stall = wb_cyc && (cnt == MAXO);
      hit = wb_cyc && q.size() > 0 && q[0].due == n;
      e_dat = (hit && !q[0].err) ? q[0].dat : 64'd0;
      chk("stall", 64'(wb_stall), 64'(e_stall));
      chk("ack", 64'(wb_ack), 64'(hit && !q[0].err));
      chk("err", 64'(wb_err), 64'(hit && q[0].err));
      chk("dat", wb_dat_o, e_dat);
      if (hit) void'(q.pop_front());
      acc = wb_cyc && wb_stb && !e_stall && rdy;
      if (acc) begin
        idx = wb_adr[6:3];
`ifdef WB_REGBANK_ERR_EN
        oor = |wb_adr[31:7];
`else
        oor = 1'b0;
`endif
        r.due = n + LAT;
        r.err = oor;
        r.dat = (!wb_we && !oor) ? mem[idx] : 64'd0;
        if (wb_we && !oor)
          for (int b = 0; b < 8; b++)
            if (wb_sel[b]) mem[idx][8*b +: 8] = wb_dat_i[8*b +: 8];
        q.push_back(r);
      end
      if (!wb_cyc) begin
        q.delete();
        cnt = 0;
      end else begin
        cnt = cnt + int'(acc) - int'(hit);
      end
      rdy = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit s, input bit w, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] se);
    wb_cyc = c; wb_stb = s; wb_we = w; wb_adr = a; wb_dat_i = d; wb_sel = se;
  endtask

  task automatic single(input bit w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] se);
    drive(1, 1, w, a, d, se);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    logic [31:0] a;
    drive(1, 1, 0, 32'h08, 0, 8'hFF);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) tick();
    single(0, 32'h08, 0, 0);
    single(1, 32'h10, 64'h1122334455667788, 8'hFF);
    single(1, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    single(0, 32'h10, 0, 0);
    for (int i = 0; i < 6; i++) single(1, 32'(i * 8), {$urandom, $urandom}, 8'($urandom));
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 32'(i * 8), 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) tick();
    drive(1, 1, 0, 32'h10, 0, 0);
    tick();
    drive(1, 1, 0, 32'h18, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    single(0, 32'h10, 0, 0);
    single(1, 32'h1000, 64'hDEADBEEFCAFEF00D, 8'hFF);
    single(0, 32'h00, 0, 0);
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 5) == 0) a = a | 32'h1000;
      drive($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), a, {$urandom, $urandom}, 8'($urandom));
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) tick();
    drive(1, 1, 0, 32'h10, 0, 0);
    repeat (2) tick();
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 16; i++) single(0, 32'(i * 8), 0, 0);
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
